// File: rtl/logic_pod_dense_packer.sv
// Bit-contiguous packer: LSB-first stream of SYM_WIDTH symbols into OUT_WIDTH FIFO words,
// with a one-entry holding register, FIFO backpressure and flush of partial residue.
module logic_pod_dense_packer #(
    parameter int SYM_WIDTH = 17,
    parameter int OUT_WIDTH = 128,
    parameter int CNT_WIDTH = $clog2(OUT_WIDTH + 1)
) (
    input  logic                 clk,
    input  logic                 rst_n,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [SYM_WIDTH-1:0] in_data,
    input  logic                 flush,
    output logic                 flush_done,
    input  logic                 fifo_full,
    output logic                 fifo_wr,
    output logic [OUT_WIDTH-1:0] fifo_wdata,
    output logic [CNT_WIDTH-1:0] fifo_wbits
);

    typedef enum logic [1:0] {RUN, FLUSH, DONE} state_t;

    state_t                 state, state_next;
    logic [OUT_WIDTH-1:0]   acc, hold, last_word;
    logic [CNT_WIDTH-1:0]   fill, last_bits;
    logic                   pending;
    logic                   accept, completes, drain, residue_wr, flush_ready;
    logic [CNT_WIDTH:0]     total, wrap_fill;
    logic [2*OUT_WIDTH-1:0] ext;

    // Accumulator bits above fill are always zero, so OR-ing the shifted symbol is enough.
    always_comb begin
        accept      = in_valid & in_ready;
        ext         = {{OUT_WIDTH{1'b0}}, acc}
                    | ({{(2*OUT_WIDTH-SYM_WIDTH){1'b0}}, in_data} << fill);
        total       = {1'b0, fill} + (CNT_WIDTH+1)'(SYM_WIDTH);
        wrap_fill   = total - (CNT_WIDTH+1)'(OUT_WIDTH);
        completes   = accept && (total >= (CNT_WIDTH+1)'(OUT_WIDTH));
        drain       = pending & ~fifo_full;
        flush_ready = (state == FLUSH) && !pending && !fifo_full;
        residue_wr  = flush_ready && (fill != '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state <= RUN;
        end else begin
            state <= state_next;
        end
    end

    always_comb begin
        state_next = state;
        case (state)
            RUN:     if (flush) state_next = FLUSH;
            FLUSH:   if (flush_ready) state_next = DONE;
            DONE:    state_next = RUN;
            default: state_next = RUN;
        endcase
    end

    // Write data is selected live; last_word keeps the bus stable between writes.
    always_comb begin
        in_ready   = (state == RUN) && !(pending && fifo_full);
        flush_done = (state == DONE);
        fifo_wr    = drain | residue_wr;
        if (drain) begin
            fifo_wdata = hold;
            fifo_wbits = CNT_WIDTH'(OUT_WIDTH);
        end else if (residue_wr) begin
            fifo_wdata = acc;
            fifo_wbits = fill;
        end else begin
            fifo_wdata = last_word;
            fifo_wbits = last_bits;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            acc       <= '0;
            fill      <= '0;
            hold      <= '0;
            pending   <= 1'b0;
            last_word <= '0;
            last_bits <= '0;
        end else begin
            if (accept) begin
                if (completes) begin
                    hold <= ext[OUT_WIDTH-1:0];
                    acc  <= ext[2*OUT_WIDTH-1:OUT_WIDTH];
                    fill <= CNT_WIDTH'(wrap_fill);
                end else begin
                    acc  <= ext[OUT_WIDTH-1:0];
                    fill <= CNT_WIDTH'(total);
                end
            end else if (residue_wr) begin
                acc  <= '0;
                fill <= '0;
            end
            pending <= completes | (pending & ~drain);
            if (fifo_wr) begin
                last_word <= fifo_wdata;
                last_bits <= fifo_wbits;
            end
        end
    end

endmodule

// File: tb/tb_logic_pod_dense_packer.sv
// Directed bench for logic_pod_dense_packer: packing, flush residue, backpressure,
// empty flush and mid-flush reset, checked against a bit-level stream model.
module tb_logic_pod_dense_packer;
    localparam int SW = 17;
    localparam int OW = 128;
    localparam int CW = 8;

    logic          clk = 1'b0;
    logic          rst_n, in_valid, in_ready, flush, flush_done, fifo_full, fifo_wr;
    logic [SW-1:0] in_data;
    logic [OW-1:0] fifo_wdata;
    logic [CW-1:0] fifo_wbits;

    int            total = 0;
    int            bad = 0;
    int            done_cnt = 0;
    logic [OW-1:0] wq_data[$];
    int            wq_bits[$];
    bit            stream[$];
    logic [OW-1:0] exp1;

    always #5 clk = ~clk;

    logic_pod_dense_packer #(.SYM_WIDTH(SW), .OUT_WIDTH(OW)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .flush(flush), .flush_done(flush_done),
        .fifo_full(fifo_full), .fifo_wr(fifo_wr), .fifo_wdata(fifo_wdata),
        .fifo_wbits(fifo_wbits)
    );

    always @(negedge clk) begin
        if (rst_n) begin
            if (fifo_wr) begin
                wq_data.push_back(fifo_wdata);
                wq_bits.push_back(int'(fifo_wbits));
            end
            if (flush_done) done_cnt++;
        end
    end

    task automatic chk(input string tag, input logic [OW-1:0] obs, input logic [OW-1:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(posedge clk);
        #1;
    endtask

    task automatic send(input logic [SW-1:0] v);
        bit ok = 1'b0;
        in_valid = 1'b1;
        in_data  = v;
        for (int n = 0; n < 50 && !ok; n++) begin
            @(negedge clk);
            ok = in_ready;
            cyc();
        end
        in_valid = 1'b0;
        chk("send_accept", OW'(ok), OW'(1));
        if (ok) for (int b = 0; b < SW; b++) stream.push_back(v[b]);
    endtask

    task automatic pulse_flush();
        flush = 1'b1;
        cyc();
        flush = 1'b0;
    endtask

    task automatic wait_done(input string tag);
        bit seen = 1'b0;
        for (int n = 0; n < 60 && !seen; n++) begin
            @(negedge clk);
            seen = flush_done;
            cyc();
        end
        chk(tag, OW'(seen), OW'(1));
    endtask

    task automatic verify(input string tag);
        int            n;
        int            nw;
        int            bits;
        logic [OW-1:0] exp;
        n  = stream.size();
        nw = (n + OW - 1) / OW;
        chk({tag, "_nwrites"}, OW'(wq_data.size()), OW'(nw));
        for (int j = 0; j < nw && j < wq_data.size(); j++) begin
            bits = ((n - j*OW) < OW) ? (n - j*OW) : OW;
            exp  = '0;
            for (int b = 0; b < bits; b++) exp[b] = stream[j*OW + b];
            chk({tag, "_word"}, wq_data[j], exp);
            chk({tag, "_wbits"}, OW'(wq_bits[j]), OW'(bits));
        end
        chk({tag, "_done_cnt"}, OW'(done_cnt), OW'(1));
        stream.delete();
        wq_data.delete();
        wq_bits.delete();
        done_cnt = 0;
    endtask

    initial begin
        rst_n = 1'b0; in_valid = 1'b0; in_data = '0; flush = 1'b0; fifo_full = 1'b0;
        cyc(); cyc();
        @(negedge clk);
        chk("rst_in_ready", OW'(in_ready), OW'(1));
        chk("rst_fifo_wr", OW'(fifo_wr), OW'(0));
        chk("rst_wdata", fifo_wdata, '0);
        chk("rst_wbits", OW'(fifo_wbits), OW'(0));
        chk("rst_flush_done", OW'(flush_done), OW'(0));
        rst_n = 1'b1;
        cyc();

        // 1) symbols 0..7 -> one full word one cycle after the 8th accept
        exp1 = '0;
        for (int i = 0; i < 8; i++) exp1 = exp1 | (OW'(i) << (SW*i));
        for (int i = 0; i < 8; i++) send(SW'(i));
        @(negedge clk);
        chk("t1_fifo_wr", OW'(fifo_wr), OW'(1));
        chk("t1_wdata", fifo_wdata, exp1);
        chk("t1_wbits", OW'(fifo_wbits), OW'(128));
        cyc();

        // 2) flush leaves an 8-bit residue of zeros, flush_done on the next cycle
        pulse_flush();
        @(negedge clk);
        chk("t2_fifo_wr", OW'(fifo_wr), OW'(1));
        chk("t2_wbits", OW'(fifo_wbits), OW'(8));
        chk("t2_wdata", fifo_wdata, '0);
        cyc();
        @(negedge clk);
        chk("t2_flush_done", OW'(flush_done), OW'(1));
        chk("t2_no_wr", OW'(fifo_wr), OW'(0));
        cyc();
        @(negedge clk);
        chk("t2_done_once", OW'(flush_done), OW'(0));
        cyc();
        verify("t2");

        // single-symbol residue with nonzero data
        send(17'h1ABCD);
        pulse_flush();
        wait_done("res_done");
        verify("res");

        // 3) 128 random symbols -> 17 full words, no residue
        for (int i = 0; i < 128; i++) send(SW'($urandom));
        pulse_flush();
        wait_done("t3_done");
        verify("t3");

        // 4) backpressure: word completes while FIFO is full
        fifo_full = 1'b1;
        for (int i = 0; i < 8; i++) send(SW'(100 + i));
        @(negedge clk);
        chk("t4_ready_low", OW'(in_ready), OW'(0));
        chk("t4_no_wr", OW'(fifo_wr), OW'(0));
        cyc();
        in_valid = 1'b1;
        in_data  = SW'(108);
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            chk("t4_held_ready", OW'(in_ready), OW'(0));
            chk("t4_held_wr", OW'(fifo_wr), OW'(0));
            cyc();
        end
        fifo_full = 1'b0;
        @(negedge clk);
        chk("t4_release_wr", OW'(fifo_wr), OW'(1));
        chk("t4_release_wbits", OW'(fifo_wbits), OW'(128));
        chk("t4_release_ready", OW'(in_ready), OW'(1));
        for (int b = 0; b < SW; b++) stream.push_back(in_data[b]);
        cyc();
        in_valid = 1'b0;
        pulse_flush();
        wait_done("t4_done");
        verify("t4");

        // 5) empty flush with repeated flush pulses during FLUSH and DONE
        flush = 1'b1;
        cyc();
        @(negedge clk);
        chk("t5_not_yet", OW'(flush_done), OW'(0));
        chk("t5_no_wr", OW'(fifo_wr), OW'(0));
        cyc();
        @(negedge clk);
        chk("t5_done", OW'(flush_done), OW'(1));
        cyc();
        flush = 1'b0;
        @(negedge clk);
        chk("t5_done_off", OW'(flush_done), OW'(0));
        cyc();
        @(negedge clk);
        chk("t5_done_off2", OW'(flush_done), OW'(0));
        cyc();
        chk("t5_done_cnt", OW'(done_cnt), OW'(1));
        chk("t5_writes", OW'(wq_data.size()), OW'(0));
        done_cnt = 0;

        // 6) reset mid-flush with a pending word and residue
        fifo_full = 1'b1;
        for (int i = 0; i < 8; i++) send(SW'(200 + i));
        pulse_flush();
        cyc(); cyc();
        wq_data.delete(); wq_bits.delete(); stream.delete(); done_cnt = 0;
        #2;
        rst_n = 1'b0;
        fifo_full = 1'b0;
        #1;
        chk("t6_in_ready", OW'(in_ready), OW'(1));
        chk("t6_fifo_wr", OW'(fifo_wr), OW'(0));
        chk("t6_wdata", fifo_wdata, '0);
        chk("t6_wbits", OW'(fifo_wbits), OW'(0));
        chk("t6_flush_done", OW'(flush_done), OW'(0));
        cyc(); cyc();
        rst_n = 1'b1;
        for (int i = 0; i < 10; i++) cyc();
        chk("t6_no_writes", OW'(wq_data.size()), OW'(0));
        chk("t6_no_done", OW'(done_cnt), OW'(0));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
